// File: rtl/waveform.sv
`default_nettype none
// ============================================================================
//  Module   : waveform
//  Brief    : Frame timing generator for one AMOLED pixel row. A free-running
//             frame counter is decoded into five active-low gate lines:
//             emission off -> init -> Vth compensate -> data scan -> emission.
//  Revision : 1.0  initial release
// ============================================================================
module waveform #(
  parameter int T_GUARD  = 100,
  parameter int T_INIT   = 1000,
  parameter int T_COMP   = 2000,
  parameter int T_SCAN   = 500,
  parameter int T_EM_DLY = 100,
  parameter int FRAME    = 60000
) (
  input  logic clk,
  input  logic reset,
  output logic vinit,
  output logic vcomp,
  output logic vscan,
  output logic vem1,
  output logic vem2
);

  localparam int CW = (FRAME > 1) ? $clog2(FRAME) : 1;

  // Phase boundaries: each phase starts where the previous one ends.
  // Windows are half-open [start, end).
  localparam int c_INIT_S_I = T_GUARD;
  localparam int c_INIT_E_I = c_INIT_S_I + T_INIT;
  localparam int c_COMP_S_I = c_INIT_E_I + T_GUARD;
  localparam int c_COMP_E_I = c_COMP_S_I + T_COMP;
  localparam int c_SCAN_S_I = c_COMP_E_I + T_GUARD;
  localparam int c_SCAN_E_I = c_SCAN_S_I + T_SCAN;
  localparam int c_EM2_S_I  = c_SCAN_E_I + T_GUARD;
  localparam int c_EM1_S_I  = c_EM2_S_I + T_EM_DLY;

  localparam logic [CW-1:0] c_INIT_S = CW'(c_INIT_S_I);
  localparam logic [CW-1:0] c_INIT_E = CW'(c_INIT_E_I);
  localparam logic [CW-1:0] c_COMP_S = CW'(c_COMP_S_I);
  localparam logic [CW-1:0] c_COMP_E = CW'(c_COMP_E_I);
  localparam logic [CW-1:0] c_SCAN_S = CW'(c_SCAN_S_I);
  localparam logic [CW-1:0] c_SCAN_E = CW'(c_SCAN_E_I);
  localparam logic [CW-1:0] c_EM2_S  = CW'(c_EM2_S_I);
  localparam logic [CW-1:0] c_EM1_S  = CW'(c_EM1_S_I);
  localparam logic [CW-1:0] c_LAST   = CW'(FRAME - 1);
  localparam logic [CW-1:0] c_ONE    = CW'(1);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic          w_init_on;
  logic          w_comp_on;
  logic          w_scan_on;
  logic          w_em1_on;
  logic          w_em2_on;
  logic          r_vinit;
  logic          r_vcomp;
  logic          r_vscan;
  logic          r_vem1;
  logic          r_vem2;

  // Next counter value and the phase it falls in. Decoding the next value
  // lets the registered outputs line up with cnt without a cycle of lag.
  always_comb begin
    w_cnt_next = (r_cnt == c_LAST) ? '0 : (r_cnt + c_ONE);
    w_init_on  = (w_cnt_next >= c_INIT_S) && (w_cnt_next < c_INIT_E);
    w_comp_on  = (w_cnt_next >= c_COMP_S) && (w_cnt_next < c_COMP_E);
    w_scan_on  = (w_cnt_next >= c_SCAN_S) && (w_cnt_next < c_SCAN_E);
    w_em2_on   = (w_cnt_next >= c_EM2_S);
    w_em1_on   = (w_cnt_next >= c_EM1_S);
  end

  // Frame counter and gate-line registers; reset forces every line inactive
  // immediately and restarts the frame from zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_vinit <= 1'b1;
      r_vcomp <= 1'b1;
      r_vscan <= 1'b1;
      r_vem1  <= 1'b1;
      r_vem2  <= 1'b1;
    end else begin
      r_cnt   <= w_cnt_next;
      r_vinit <= ~w_init_on;
      r_vcomp <= ~w_comp_on;
      r_vscan <= ~w_scan_on;
      r_vem1  <= ~w_em1_on;
      r_vem2  <= ~w_em2_on;
    end
  end

  assign vinit = r_vinit;
  assign vcomp = r_vcomp;
  assign vscan = r_vscan;
  assign vem1  = r_vem1;
  assign vem2  = r_vem2;

endmodule
`default_nettype wire

// File: tb/tb_waveform.sv
`default_nettype none
// ============================================================================
//  Module   : tb_waveform
//  Brief    : Scoreboard bench for waveform. A reference counter pushes the
//             expected gate-line pattern each clock; a monitor pops and
//             compares on the falling edge. Shortened frame length.
//  Revision : 1.0  initial release
// ============================================================================
module tb_waveform;

  localparam int FRAME = 6000;

  logic clk;
  logic reset;
  logic vinit;
  logic vcomp;
  logic vscan;
  logic vem1;
  logic vem2;

  int npass = 0;
  int ntot  = 0;

  int m_cnt     = 0;
  int since_rel = 0;
  logic [4:0] sb_q[$];
  int falls[$];
  logic prev_vinit = 1'b1;

  waveform #(
    .T_GUARD  (100),
    .T_INIT   (1000),
    .T_COMP   (2000),
    .T_SCAN   (500),
    .T_EM_DLY (100),
    .FRAME    (FRAME)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .vinit (vinit),
    .vcomp (vcomp),
    .vscan (vscan),
    .vem1  (vem1),
    .vem2  (vem2)
  );

  // 100 MHz clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hand-derived phase table, {vinit,vcomp,vscan,vem1,vem2}
  function automatic logic [4:0] exp_out(input int c);
    logic [4:0] e;
    e = 5'b11111;
    if (c >= 100 && c < 1100)       e[4] = 1'b0;
    else if (c >= 1200 && c < 3200) e[3] = 1'b0;
    else if (c >= 3300 && c < 3800) e[2] = 1'b0;
    else if (c >= 3900 && c < 4000) e[0] = 1'b0;
    else if (c >= 4000)             e[1:0] = 2'b00;
    return e;
  endfunction

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] req);
    ntot++;
    if (act === req) npass++;
    else $display("FAIL %s t=%0t actual=%b required=%b", name, $time, act, req);
  endtask

  // Reference model: advance the frame counter and queue the expectation
  always @(posedge clk) begin
    if (!reset) begin
      m_cnt     = 0;
      since_rel = 0;
    end else begin
      m_cnt     = (m_cnt == FRAME - 1) ? 0 : m_cnt + 1;
      since_rel = since_rel + 1;
    end
    sb_q.push_back(exp_out(m_cnt));
  end

  // Monitor: compare outputs and exclusion rules every cycle
  always @(negedge clk) begin
    logic [4:0] act;
    logic [4:0] req;
    act = {vinit, vcomp, vscan, vem1, vem2};
    if (sb_q.size() == 0) begin
      check("sb_underflow", 5'd0, 5'd1);
    end else begin
      req = sb_q.pop_front();
      if (!reset) req = 5'b11111;
      check("outputs", act, req);
    end
    check("mutex_one_low", {4'd0, ($countones(~act[4:2]) <= 1)}, 5'd1);
    check("mutex_em_vs_gate",
          {4'd0, !((!act[1] || !act[0]) && (act[4:2] != 3'b111))}, 5'd1);
    check("mutex_em1_vs_em2", {4'd0, !(!act[1] && act[0])}, 5'd1);
    if (prev_vinit && !vinit) falls.push_back(since_rel);
    prev_vinit = vinit;
  end

  // Watchdog
  initial begin
    #1_000_000;
    $display("FAIL watchdog t=%0t actual=running required=finished", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int exp_falls[5];
    exp_falls = '{100, 6100, 12100, 18100, 100};

    reset = 1'b0;
    #20;
    check("reset_outputs", {vinit, vcomp, vscan, vem1, vem2}, 5'b11111);
    #2 reset = 1'b1;

    // Three full frames, then into EMIT of the fourth (cnt 5000)
    repeat (3 * FRAME + 5000) @(posedge clk);
    #2;
    check("pre_reset_emit", {vinit, vcomp, vscan, vem1, vem2}, 5'b11100);
    reset = 1'b0;
    #1;
    check("async_reset", {vinit, vcomp, vscan, vem1, vem2}, 5'b11111);

    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    repeat (4200) @(posedge clk);
    @(negedge clk);
    #1;

    // vinit falling edges: 3 in the first 3 frames, period FRAME, and the
    // post-reset restart begins again at cnt 0
    check("vinit_fall_count", 5'(falls.size()), 5'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < falls.size()) begin
        ntot++;
        if (falls[i] == exp_falls[i]) npass++;
        else $display("FAIL vinit_fall[%0d] actual=%0d required=%0d", i, falls[i], exp_falls[i]);
      end
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
`default_nettype wire
